// File: rtl/mux81_pkg.sv
// Shared constants, state encoding and helpers for the 8-requester mux arbiter.
package mux81_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;
  localparam logic [SEL_W-1:0] SEL_RST = 3'd0;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/mux81_rr_pick.sv
// Combinational round-robin pick: first set request scanning from ptr+1 around to ptr.
module mux81_rr_pick
  import mux81_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // k = 8 wraps to ptr itself, so a lone current grantee is re-picked last
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin arbiter driving the 8:1 mux select, with per-grant hold limit and registered data.
// Optional MUX81_ARB_LOCK_EN adds a lock input that suppresses hold expiry.
//
// state    | meaning
// ST_IDLE  | no grant, gnt = 0, sel keeps last value
// ST_GRANT | one requester granted, cnt counts cycles of the current grant
module mux81_rr_arbiter
  import mux81_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MUX81_ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             y,
  output logic             y_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             under_lim;
  logic             hold_ok;

  mux81_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (idx)
  );

  assign under_lim = (cnt < HOLD_LIM);
`ifdef MUX81_ARB_LOCK_EN
  assign hold_ok = under_lim || lock;
`else
  assign hold_ok = under_lim;
`endif

  assign busy = (state == ST_GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= PTR_RST;
      sel   <= SEL_RST;
      cnt   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_GRANT;
            gnt   <= onehot(idx);
            sel   <= idx;
            ptr   <= idx;
            cnt   <= CNT_W'(1);
          end else begin
            gnt <= '0;
          end
        end
        default: begin
          if (req[ptr] && hold_ok) begin
            // saturates at the limit while locked
            if (under_lim) cnt <= cnt + CNT_W'(1);
          end else if (found) begin
            gnt <= onehot(idx);
            sel <= idx;
            ptr <= idx;
            cnt <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
            gnt   <= '0;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      if (busy) y <= data[sel];
      y_valid <= busy;
    end
  end

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Directed self-checking bench for mux81_rr_arbiter (HOLD_MAX=4); lock tests need MUX81_ARB_LOCK_EN.
module tb_mux81_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] data;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       y;
  logic       y_valid;
  logic       busy;
`ifdef MUX81_ARB_LOCK_EN
  logic       lock;
`endif

  int checks = 0;
  int errors = 0;

  mux81_rr_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MUX81_ARB_LOCK_EN
    .lock    (lock),
`endif
    .req     (req),
    .data    (data),
    .sel     (sel),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] data;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
    logic       y_valid;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    data  = 8'h00;
`ifdef MUX81_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //                req    data   gnt    sel   busy y     yv
    vecs[0]  = '{8'h00, 8'hA5, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h01, 8'hA5, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 8'hA5, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{8'h01, 8'hA5, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{8'h00, 8'hA5, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'hA4, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'h04, 8'hA5, 8'h04, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{8'h04, 8'hA5, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{8'h22, 8'hA5, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{8'h22, 8'hA5, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{8'h02, 8'hA5, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{8'h02, 8'hA5, 8'h02, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{8'h00, 8'h5A, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req   = 8'h00;
    data  = 8'h00;
`ifdef MUX81_ARB_LOCK_EN
    lock  = 1'b0;
`endif
    #1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_sel", {5'd0, sel}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_y", {7'd0, y}, 8'd0);
    check("rst_yv", {7'd0, y_valid}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      req  = vecs[i].req;
      data = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_gnt", i), gnt, vecs[i].gnt);
      check($sformatf("v%0d_sel", i), {5'd0, sel}, {5'd0, vecs[i].sel});
      check($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].busy});
      check($sformatf("v%0d_y", i), {7'd0, y}, {7'd0, vecs[i].y});
      check($sformatf("v%0d_yv", i), {7'd0, y_valid}, {7'd0, vecs[i].y_valid});
    end

    // all requesting: each requester held exactly 4 cycles, rotation 0..7,0
    do_reset();
    @(negedge clk);
    req  = 8'hFF;
    data = 8'h0F;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr_gnt_c%0d", c), gnt, 8'h01 << ((c / 4) % 8));
      check($sformatf("rr_sel_c%0d", c), {5'd0, sel}, 8'((c / 4) % 8));
      if (c > 0) check($sformatf("rr_y_c%0d", c), {7'd0, y}, {7'd0, ((((c - 1) / 4) % 8) < 4)});
    end

    // lone requester 6 is re-granted at every expiry without a gap
    @(negedge clk);
    req = 8'h40;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("solo_gnt_c%0d", c), gnt, 8'h40);
      check($sformatf("solo_busy_c%0d", c), {7'd0, busy}, 8'd1);
    end

    // asynchronous reset mid-grant
    data = 8'h40;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 8'h00);
    check("arst_sel", {5'd0, sel}, 8'd0);
    check("arst_busy", {7'd0, busy}, 8'd0);
    check("arst_y", {7'd0, y}, 8'd0);
    check("arst_yv", {7'd0, y_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h80;
    data  = 8'h80;
    @(posedge clk);
    #1;
    check("post_rst_gnt", gnt, 8'h80);
    check("post_rst_sel", {5'd0, sel}, 8'd7);
    check("post_rst_yv0", {7'd0, y_valid}, 8'd0);
    @(posedge clk);
    #1;
    check("post_rst_y", {7'd0, y}, 8'd1);
    check("post_rst_yv1", {7'd0, y_valid}, 8'd1);

`ifdef MUX81_ARB_LOCK_EN
    do_reset();
    @(negedge clk);
    req  = 8'h18;
    lock = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("lock_gnt_c%0d", c), gnt, 8'h08);
    end
    @(negedge clk);
    lock = 1'b0;
    @(posedge clk);
    #1;
    check("unlock_gnt", gnt, 8'h10);
    check("unlock_sel", {5'd0, sel}, 8'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
